// File: rtl/jtag_host_driver.sv
// jtag_host_driver: on-chip JTAG initiator turning reset / IR scan / DR scan / idle commands
// into TCK/TMS/TDI sequences. Define JTAG_TRST_EN to add trst_out for the target's TAP reset.
module jtag_host_driver #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
`ifdef JTAG_TRST_EN
    output logic               trst_out,
`endif
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck_out,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [1:0]  OP_TLR = 2'd0;
    localparam logic [1:0]  OP_IR  = 2'd1;
    localparam logic [1:0]  OP_RUN = 2'd3;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_TLR, S_HDR, S_SHIFT, S_EXIT, S_RUN} state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   div_cnt, div_d;
    logic [CNT_W-1:0]   bit_cnt, bit_d, seg_len;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d, len_clamp;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_data_d;
    logic               tck_d, tms_d, tdi_d, rsp_valid_d, cmd_ready_d, busy_d;
    logic               accept, tick, rise, fall, last_bit, done, zero_len;
`ifdef JTAG_TRST_EN
    logic               trst_d;
`endif

    // TMS/TDI for bit idx of a segment; every segment except SHIFT is a fixed pattern
    function automatic logic [1:0] seq_bits(input state_t st, input logic [CNT_W-1:0] idx,
                                            input logic [1:0] op, input logic [LEN_W-1:0] len,
                                            input logic [MAX_LEN-1:0] data);
        logic t;
        logic d;
        t = 1'b0;
        d = 1'b0;
        case (st)
            S_INIT, S_TLR: t = (idx < CNT_W'(5));
            S_HDR:         t = (op == OP_IR) ? (idx < CNT_W'(2)) : (idx == '0);
            S_SHIFT: begin
                t = (idx == CNT_W'(len) - CNT_W'(1));
                d = |(data & (MAX_LEN'(1) << idx));
            end
            S_EXIT:        t = (idx == '0);
            default:       t = 1'b0;
        endcase
        return {t, d};
    endfunction

    assign accept    = cmd_valid && cmd_ready;
    assign len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign tick      = (state != S_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise      = tick && !tck_out;
    assign fall      = tick && tck_out;
    assign last_bit  = (bit_cnt == seg_len - CNT_W'(1));
    assign done      = fall && last_bit && (state inside {S_TLR, S_EXIT, S_RUN});
    assign zero_len  = accept && (cmd_op != OP_TLR) && (len_clamp == '0);

    always_comb begin
        seg_len = CNT_W'(6);
        case (state)
            S_HDR:          seg_len = (op_q == OP_IR) ? CNT_W'(4) : CNT_W'(3);
            S_SHIFT, S_RUN: seg_len = CNT_W'(len_q);
            S_EXIT:         seg_len = CNT_W'(2);
            default:        seg_len = CNT_W'(6);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= state_d;
    end

    // Segments advance on the TCK falling edge that ends their last bit
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_TLR)       state_d = S_TLR;
                    else if (len_clamp == '0)   state_d = S_IDLE;
                    else if (cmd_op == OP_RUN)  state_d = S_RUN;
                    else                        state_d = S_HDR;
                end
            end
            S_HDR:   if (fall && last_bit) state_d = S_SHIFT;
            S_SHIFT: if (fall && last_bit) state_d = S_EXIT;
            default: if (fall && last_bit) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d        = accept ? cmd_op    : op_q;
        len_d       = accept ? len_clamp : len_q;
        data_d      = accept ? cmd_data  : data_q;
        bit_d       = (state_d != state) ? '0 : (fall ? bit_cnt + CNT_W'(1) : bit_cnt);
        div_d       = (state == S_IDLE || tick) ? '0 : div_cnt + DIV_W'(1);
        tck_d       = rise ? 1'b1 : (fall ? 1'b0 : tck_out);
        tms_d       = tms;
        tdi_d       = tdi;
        cap_d       = cap_q;
        rsp_valid_d = done || zero_len;
        rsp_data_d  = rsp_data;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        if (accept || fall)
            {tms_d, tdi_d} = seq_bits(state_d, bit_d, op_d, len_d, data_d);
        if (accept)
            cap_d = '0;
        else if (rise && state == S_SHIFT)
            cap_d = cap_q | (MAX_LEN'(tdo) << bit_cnt);
        if (done)
            rsp_data_d = (state == S_EXIT) ? cap_q : '0;
        else if (zero_len)
            rsp_data_d = '0;
`ifdef JTAG_TRST_EN
        trst_d = (state_d inside {S_INIT, S_TLR});
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            op_q      <= '0;
            len_q     <= '0;
            data_q    <= '0;
            cap_q     <= '0;
            tck_out   <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef JTAG_TRST_EN
            trst_out  <= 1'b1;
`endif
        end else begin
            div_cnt   <= div_d;
            bit_cnt   <= bit_d;
            op_q      <= op_d;
            len_q     <= len_d;
            data_q    <= data_d;
            cap_q     <= cap_d;
            tck_out   <= tck_d;
            tms       <= tms_d;
            tdi       <= tdi_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
`ifdef JTAG_TRST_EN
            trst_out  <= trst_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: directed vectors for jtag_host_driver against a small TAP target model
// (IR width 4, IDCODE=0001, BYPASS=1111).
module tb_jtag_host_driver;

    localparam int unsigned MAX_LEN    = 32;
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);
    localparam logic [31:0] IDCODE_VAL = 32'h1234_5677;
    localparam logic [3:0]  IR_IDCODE  = 4'b0001;
    localparam logic [3:0]  IR_BYPASS  = 4'b1111;

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_t;

    typedef struct {
        logic [1:0]       op;
        logic [LEN_W-1:0] len;
        logic [31:0]      data;
        logic [31:0]      exp_rsp;
        int               exp_rises;
        logic [63:0]      exp_tms;
        int               exp_lat;
        logic [3:0]       exp_ir;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck_out;
    logic               tms;
    logic               tdi;
    logic               tdo = 1'b0;
`ifdef JTAG_TRST_EN
    logic               trst_out;
`endif

    tap_t        tap = T_TLR;
    logic [3:0]  ir = IR_IDCODE;
    logic [3:0]  ir_sr = 4'b0;
    logic [31:0] dr_sr = 32'b0;
    logic [63:0] tms_hist = 64'b0;
    int          rise_total = 0;
    int          rsp_cnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs[11];

    jtag_host_driver #(.CLK_DIV(2), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef JTAG_TRST_EN
        .trst_out  (trst_out),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck_out   (tck_out),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PADR;
            T_PADR:  return m ? T_EX2DR : T_PADR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAIR;
            T_PAIR:  return m ? T_EX2IR : T_PAIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    // Target TAP: state and shift registers move on TCK rise, TDO updates on TCK fall
    always @(posedge tck_out) begin
        tms_hist   <= {tms, tms_hist[63:1]};
        rise_total <= rise_total + 1;
        case (tap)
            T_TLR:   ir    <= IR_IDCODE;
            T_CAPIR: ir_sr <= 4'b0001;
            T_SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
            T_UPIR:  ir    <= ir_sr;
            T_CAPDR: dr_sr <= (ir == IR_IDCODE) ? IDCODE_VAL : 32'h0;
            T_SHDR:  dr_sr <= (ir == IR_IDCODE) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    always @(negedge tck_out)
        tdo <= (tap == T_SHIR) ? ir_sr[0] : ((tap == T_SHDR) ? dr_sr[0] : 1'b0);

    always @(posedge clk)
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!cmd_ready && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    function automatic logic [63:0] last_tms(input int n);
        if (n <= 0) return 64'h0;
        if (n > 64) return '1;
        return tms_hist >> (64 - n);
    endfunction

    // Offer one command, then follow it to rsp_valid and check everything it produced
    task automatic run_vec(input string tag, input vec_t v);
        int base_rises;
        int lat;
        int got_rises;
        cmd_valid  = 1'b1;
        cmd_op     = v.op;
        cmd_len    = v.len;
        cmd_data   = v.data;
        base_rises = rise_total;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_op     = ~v.op;
        cmd_len    = ~v.len;
        cmd_data   = ~v.data;
        lat = 0;
        while (!rsp_valid && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        got_rises = rise_total - base_rises;
        chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, " rsp_data"}, 64'(rsp_data), 64'(v.exp_rsp));
        chk({tag, " tck_rises"}, 64'(got_rises), 64'(v.exp_rises));
        chk({tag, " tms_seq"}, last_tms(got_rises), v.exp_tms);
        chk({tag, " tap_state"}, 64'(tap), 64'(T_RTI));
        chk({tag, " target_ir"}, 64'(ir), 64'(v.exp_ir));
        chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        int cyc;
        int base;
        int base_rsp;

        vecs[0]  = '{2'd1, LEN_W'(4),  32'h1,        32'h1,        10, 64'h183,          40,  IR_IDCODE};
        vecs[1]  = '{2'd2, LEN_W'(32), 32'h0,        IDCODE_VAL,   37, 64'hC_0000_0001,  148, IR_IDCODE};
        vecs[2]  = '{2'd2, LEN_W'(16), 32'hFFFF,     32'h5677,     21, 64'hC_0001,       84,  IR_IDCODE};
        vecs[3]  = '{2'd1, LEN_W'(4),  32'hF,        32'h1,        10, 64'h183,          40,  IR_BYPASS};
        vecs[4]  = '{2'd2, LEN_W'(8),  32'hA5,       32'h4A,       13, 64'hC01,          52,  IR_BYPASS};
        vecs[5]  = '{2'd3, LEN_W'(3),  32'h7,        32'h0,        3,  64'h0,            12,  IR_BYPASS};
        vecs[6]  = '{2'd2, LEN_W'(0),  32'hFF,       32'h0,        0,  64'h0,            0,   IR_BYPASS};
        vecs[7]  = '{2'd0, LEN_W'(5),  32'h3,        32'h0,        6,  64'h1F,           24,  IR_IDCODE};
        vecs[8]  = '{2'd2, LEN_W'(40), 32'hFFFFFFFF, IDCODE_VAL,   37, 64'hC_0000_0001,  148, IR_IDCODE};
        vecs[9]  = '{2'd1, LEN_W'(0),  32'hF,        32'h0,        0,  64'h0,            0,   IR_IDCODE};
        vecs[10] = '{2'd2, LEN_W'(1),  32'h1,        32'h1,        6,  64'h19,           24,  IR_IDCODE};

        repeat (3) @(posedge clk);
        #1;
        chk("reset tck_out", 64'(tck_out), 64'(0));
        chk("reset tms", 64'(tms), 64'(1));
        chk("reset tdi", 64'(tdi), 64'(0));
        chk("reset cmd_ready", 64'(cmd_ready), 64'(0));
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset rsp_data", 64'(rsp_data), 64'(0));
        chk("reset busy", 64'(busy), 64'(1));
`ifdef JTAG_TRST_EN
        chk("reset trst_out", 64'(trst_out), 64'(1));
`endif
        base = rise_total;
        reset = 1'b0;
        wait_ready(cyc);
        chk("init cmd_ready", 64'(cmd_ready), 64'(1));
        chk("init tck_rises", 64'(rise_total - base), 64'(6));
        chk("init tms_seq", last_tms(rise_total - base), 64'h1F);
        chk("init tap_state", 64'(tap), 64'(T_RTI));
        chk("init no rsp_valid", 64'(rsp_cnt), 64'(0));
        chk("init busy", 64'(busy), 64'(0));
`ifdef JTAG_TRST_EN
        chk("idle trst_out", 64'(trst_out), 64'(0));
`endif

        for (int i = 0; i < 11; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        @(posedge clk); #1;
        chk("rsp_valid pulse width", 64'(rsp_valid), 64'(0));
        chk("rsp_data hold", 64'(rsp_data), 64'(vecs[10].exp_rsp));

        // Abort a 32-bit DR scan in the middle of SHIFT
        base_rsp  = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = LEN_W'(32);
        cmd_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort in shift", 64'(tap), 64'(T_SHDR));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort reset tck_out", 64'(tck_out), 64'(0));
        chk("abort reset tms", 64'(tms), 64'(1));
        chk("abort reset cmd_ready", 64'(cmd_ready), 64'(0));
        chk("abort reset rsp_data", 64'(rsp_data), 64'(0));
`ifdef JTAG_TRST_EN
        chk("abort reset trst_out", 64'(trst_out), 64'(1));
`endif
        @(posedge clk); #1;
        base  = rise_total;
        reset = 1'b0;
        wait_ready(cyc);
        chk("reinit cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reinit tck_rises", 64'(rise_total - base), 64'(6));
        chk("reinit tms_seq", last_tms(rise_total - base), 64'h1F);
        chk("reinit tap_state", 64'(tap), 64'(T_RTI));
        chk("abort no rsp_valid", 64'(rsp_cnt), 64'(base_rsp));
        run_vec("post-abort", vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
